zl_gf_inv: RTL and testbench
============================

// Module: zl_gf_inv
// PURPOSE
//  Iterative GF(2^m) inverter: out = a^(2^m-2) = a^-1, computed by square-and-multiply.
//  One zl_gf_mul instance is time-shared between square and multiply steps under a small FSM.
//  Feeds RS/BCH decoder stages (Forney/Chien normalisation) that need an occasional division.
//  Area matters more than throughput here, so one multiplier is used instead of a log-depth tree.
// PARAMETERS
//  Gf_width  8      field width m; must be >= 3
//  Gf_poly   'h11D  field polynomial; bits [Gf_width-1:0] are passed to the multiplier
// PORTS
//  clk          in   1         clock
//  rst          in   1         asynchronous reset, active high
//  in_req       in   1         input operand valid
//  in_ack       out  1         block can accept; operand transfers when in_req & in_ack at a rising edge
//  in_data      in   Gf_width  operand a
//  out_req      out  1         result valid; held until out_ack
//  out_ack      in   1         consumer accepts; transfer when out_req & out_ack at a rising edge
//  out_data     out  Gf_width  a^-1 (0 when a==0); stable while out_req=1
//  out_zero     out  1         operand was zero (no inverse exists); qualified by out_req
//  out_chk_fail out  1         self-check mismatch; qualified by out_req; constant 0 without ZL_GF_INV_CHECK_EN
// BEHAVIOUR
//  - Reset: state=IDLE, in_ack=1, out_req=0, out_data=0, out_zero=0, out_chk_fail=0, cnt=0.
//    Asserting rst mid-operation aborts the operation; the result is discarded.
//  - Registers:
//    - a_reg, r: Gf_width bits each.
//    - cnt: $clog2(Gf_width) bits.
//  - Multiplier operands:
//    - op_a = r.
//    - op_b = r in SQR, a_reg otherwise.
//    - The product is combinational and is registered into r.
//  - FSM; in_ack = (state==IDLE), out_req = (state==DONE):
//    - IDLE: on in_req: a_reg<=in_data, r<=in_data, cnt<=0 -> SQR.
//    - SQR:  r<=r*r; if cnt==Gf_width-2 -> CHK (macro) / DONE; else -> MUL.
//    - MUL:  r<=r*a_reg; cnt<=cnt+1 -> SQR.
//    - CHK:  out_chk_fail <= (r*a_reg != 1) & (a_reg != 0) -> DONE. Present only with the macro.
//    - DONE: hold outputs; on out_ack -> IDLE.
//  - Latency: out_req rises 2*Gf_width-3 edges after the accepting edge (13 for m=8); +1 with macro.
//  - Throughput: one operand per 2*Gf_width-1 cycles. DONE->IDLE always costs one cycle;
//    there is no accept-while-done bypass.
//  - out_zero = (a_reg==0), registered at accept. A zero operand naturally yields out_data=0.
//  - in_data is ignored outside IDLE.
//  - in_req / out_ack may be held high continuously; the block back-to-backs at max throughput.
// CONFIGURATION
//  ZL_GF_INV_CHECK_EN defined:
//   - Adds the CHK state: one extra multiply r*a_reg through the same multiplier.
//   - out_chk_fail = 1 if the product is not 1 and a != 0.
//  ZL_GF_INV_CHECK_EN undefined:
//   - No CHK state and no extra cycle.
//   - out_chk_fail tied to 0.
// STRUCTURE
//  - Shared include zl_gf_defs.vh:
//    - FSM state encodings (IDLE, SQR, MUL, CHK, DONE).
//    - Default field constants (GF8_WIDTH=8, GF8_POLY='h11D).
//  - One sub-module: zl_gf_mul, instanced once with Gf_width/Gf_poly passed through.
//  - The remainder is FSM, cnt, a_reg/r registers and the op_b mux.
// TESTING (Gf_width=8, Gf_poly='h11D)
//  - in_data=8'h02 -> out_data=8'h8E, out_zero=0, out_req rises 13 edges after accept (14 with macro).
//  - in_data=8'h03 -> 8'hF4. in_data=8'h01 -> 8'h01.
//  - in_data=8'h00 -> out_data=8'h00, out_zero=1, out_chk_fail=0.
//  - Sweep all 255 nonzero a, in_req/out_ack held high:
//    - every out_data*a==1 (golden model).
//    - out_chk_fail never 1.
//    - accepts spaced exactly 15 cycles (16 with macro).
//  - out_ack held low 20 cycles in DONE -> out_data/out_req stable, in_ack=0; new in_req ignored.
//  - rst pulsed during MUL -> next cycle in_ack=1, out_req=0; following operand 8'h02 gives 8'h8E.

Source files
------------

// File: rtl/zl_gf_inv_pkg.sv
// Shared definitions for the GF(2^m) inverter: FSM state encodings and default field constants.
package zl_gf_inv_pkg;

   localparam int unsigned GF8_WIDTH = 8;
   localparam logic [31:0] GF8_POLY  = 32'h0000_011D;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SQR  = 3'd1,
      ST_MUL  = 3'd2,
      ST_CHK  = 3'd3,
      ST_DONE = 3'd4
   } gf_inv_state_e;

endpackage

// File: rtl/zl_gf_mul.sv
// Combinational GF(2^m) multiplier; Gf_poly holds the reduction polynomial without its x^m term.
module zl_gf_mul
   import zl_gf_inv_pkg::*;
#(
   parameter int unsigned           Gf_width = GF8_WIDTH,
   parameter logic [Gf_width-1:0]   Gf_poly  = Gf_width'(GF8_POLY)
) (
   input  logic [Gf_width-1:0] a_i,
   input  logic [Gf_width-1:0] b_i,
   output logic [Gf_width-1:0] p_o
);

   logic [Gf_width-1:0] acc;
   logic [Gf_width-1:0] sh;

   // Shift-and-add with reduction folded into every shift of the multiplicand.
   always_comb begin
      acc = '0;
      sh  = a_i;
      for (int i = 0; i < Gf_width; i++) begin
         if (b_i[i]) begin
            acc = acc ^ sh;
         end
         sh = {sh[Gf_width-2:0], 1'b0} ^ (sh[Gf_width-1] ? Gf_poly : '0);
      end
      p_o = acc;
   end

endmodule

// File: rtl/zl_gf_inv.sv
// Iterative GF(2^m) inverter: a^-1 = a^(2^m-2) by square-and-multiply on one shared multiplier.
// Build option ZL_GF_INV_CHECK_EN adds a CHK state that flags results where r*a != 1.
module zl_gf_inv
   import zl_gf_inv_pkg::*;
#(
   parameter int unsigned Gf_width = GF8_WIDTH,
   parameter logic [31:0] Gf_poly  = GF8_POLY
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                in_req_i,
   output logic                in_ack_o,
   input  logic [Gf_width-1:0] in_data_i,
   output logic                out_req_o,
   input  logic                out_ack_i,
   output logic [Gf_width-1:0] out_data_o,
   output logic                out_zero_o,
   output logic                out_chk_fail_o
);

   localparam int unsigned     CntW    = $clog2(Gf_width);
   localparam logic [CntW-1:0] CntLast = CntW'(Gf_width - 2);

   gf_inv_state_e       state_q, state_d;
   logic [Gf_width-1:0] a_q, a_d;
   logic [Gf_width-1:0] r_q, r_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic                zero_q, zero_d;
   logic [Gf_width-1:0] op_b;
   logic [Gf_width-1:0] prod;

   assign op_b = (state_q == ST_SQR) ? r_q : a_q;

   zl_gf_mul #(
      .Gf_width (Gf_width),
      .Gf_poly  (Gf_poly[Gf_width-1:0])
   ) u_mul (
      .a_i (r_q),
      .b_i (op_b),
      .p_o (prod)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         zero_q  <= zero_d;
      end
   end

   // Each SQR/MUL pair extends the exponent run of ones; the final SQR leaves 2^m-2.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      zero_d  = zero_q;
      case (state_q)
         ST_IDLE: begin
            if (in_req_i) begin
               a_d     = in_data_i;
               r_d     = in_data_i;
               cnt_d   = '0;
               zero_d  = (in_data_i == '0);
               state_d = ST_SQR;
            end
         end
         ST_SQR: begin
            r_d = prod;
            if (cnt_q == CntLast) begin
`ifdef ZL_GF_INV_CHECK_EN
               state_d = ST_CHK;
`else
               state_d = ST_DONE;
`endif
            end else begin
               state_d = ST_MUL;
            end
         end
         ST_MUL: begin
            r_d     = prod;
            cnt_d   = cnt_q + CntW'(1);
            state_d = ST_SQR;
         end
`ifdef ZL_GF_INV_CHECK_EN
         ST_CHK: begin
            state_d = ST_DONE;
         end
`endif
         ST_DONE: begin
            if (out_ack_i) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

`ifdef ZL_GF_INV_CHECK_EN
   localparam logic [Gf_width-1:0] GfOne = Gf_width'(1);

   logic chk_q, chk_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         chk_q <= 1'b0;
      end else begin
         chk_q <= chk_d;
      end
   end

   // In CHK the multiplier sees r*a_reg, which must be 1 for any nonzero operand.
   always_comb begin
      chk_d = chk_q;
      if (state_q == ST_CHK) begin
         chk_d = (prod != GfOne) && (a_q != '0);
      end
   end

   assign out_chk_fail_o = chk_q;
`else
   assign out_chk_fail_o = 1'b0;
`endif

   assign in_ack_o   = (state_q == ST_IDLE);
   assign out_req_o  = (state_q == ST_DONE);
   assign out_data_o = r_q;
   assign out_zero_o = zero_q;

endmodule

// File: tb/tb_zl_gf_inv.sv
// Self-checking bench for zl_gf_inv (m=8, poly 0x11D) against a polynomial-division reference model.
// Honours ZL_GF_INV_CHECK_EN for the expected latency and accept spacing.
module tb_zl_gf_inv;

   localparam int PolyRef = 'h11D;
`ifdef ZL_GF_INV_CHECK_EN
   localparam int LatExp = 14;
`else
   localparam int LatExp = 13;
`endif
   localparam int PeriodExp = LatExp + 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       inReq;
   logic       inAck;
   logic [7:0] inData;
   logic       outReq;
   logic       outAck;
   logic [7:0] outData;
   logic       outZero;
   logic       outChkFail;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   zl_gf_inv #(
      .Gf_width (8),
      .Gf_poly  (32'h11D)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .in_req_i       (inReq),
      .in_ack_o       (inAck),
      .in_data_i      (inData),
      .out_req_o      (outReq),
      .out_ack_i      (outAck),
      .out_data_o     (outData),
      .out_zero_o     (outZero),
      .out_chk_fail_o (outChkFail)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Carry-less product followed by long division by the field polynomial.
   function automatic int gfMulRef(input int a, input int b);
      int prod;
      prod = 0;
      for (int i = 0; i < 8; i++) begin
         if (((b >> i) & 1) != 0) prod = prod ^ (a << i);
      end
      for (int bitPos = 14; bitPos >= 8; bitPos--) begin
         if (((prod >> bitPos) & 1) != 0) prod = prod ^ (PolyRef << (bitPos - 8));
      end
      return prod;
   endfunction

   // Inverse by exhaustive search; zero maps to zero.
   function automatic logic [7:0] gfInvRef(input int a);
      for (int x = 1; x < 256; x++) begin
         if (gfMulRef(a, x) == 1) return 8'(x);
      end
      return 8'h00;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Hands one operand over, then waits for the result and checks it; leaves the block in DONE.
   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] expData, input string tag);
      int guard;
      int lat;
      inReq  = 1'b1;
      inData = a;
      guard  = 0;
      while (inAck !== 1'b1 && guard < 50) begin
         tick();
         guard++;
      end
      checkOutput({tag, "_accept_timeout"}, 32'(guard >= 50), 32'd0);
      tick();
      inReq  = 1'b0;
      inData = 8'($urandom);
      lat    = 0;
      while (outReq !== 1'b1 && lat < 100) begin
         tick();
         lat++;
      end
      checkOutput({tag, "_latency"}, 32'(lat), 32'(LatExp));
      checkOutput({tag, "_data"}, 32'(outData), 32'(expData));
      checkOutput({tag, "_zero"}, 32'(outZero), 32'(a == 8'h00));
      checkOutput({tag, "_chk"}, 32'(outChkFail), 32'd0);
   endtask

   task automatic releaseOutput(input string tag);
      outAck = 1'b1;
      tick();
      outAck = 1'b0;
      checkOutput({tag, "_release"}, 32'({outReq, inAck}), 32'b01);
   endtask

   initial begin
      int guard;
      int prevAccept;
      int accCyc;
      int nRand;
      logic [7:0] randA;

      rst    = 1'b1;
      inReq  = 1'b0;
      inData = 8'h00;
      outAck = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      #1;
      checkOutput("reset_in_ack", 32'(inAck), 32'd1);
      checkOutput("reset_out_req", 32'(outReq), 32'd0);
      checkOutput("reset_out_data", 32'(outData), 32'd0);
      checkOutput("reset_out_zero", 32'(outZero), 32'd0);
      checkOutput("reset_chk_fail", 32'(outChkFail), 32'd0);
      tick();

      applyStimulus(8'h02, 8'h8E, "inv02");
      releaseOutput("inv02");
      applyStimulus(8'h03, 8'hF4, "inv03");
      releaseOutput("inv03");
      applyStimulus(8'h01, 8'h01, "inv01");
      releaseOutput("inv01");
      applyStimulus(8'h00, 8'h00, "inv00");
      releaseOutput("inv00");

      // Back-pressure: result must hold in DONE and a new request must be ignored.
      applyStimulus(8'h03, 8'hF4, "hold");
      inReq  = 1'b1;
      inData = 8'h55;
      for (int i = 0; i < 20; i++) begin
         tick();
         checkOutput("hold_req_ack", 32'({outReq, inAck}), 32'b10);
         checkOutput("hold_data", 32'(outData), 32'hF4);
      end
      inReq = 1'b0;
      releaseOutput("hold");
      repeat (3) tick();
      checkOutput("hold_no_ghost", 32'(outReq), 32'd0);

      // Abort mid-operation with an asynchronous reset pulse while in MUL.
      inReq  = 1'b1;
      inData = 8'h02;
      guard  = 0;
      while (inAck !== 1'b1 && guard < 50) begin
         tick();
         guard++;
      end
      tick();
      inReq = 1'b0;
      tick();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      tick();
      checkOutput("abort_in_ack", 32'(inAck), 32'd1);
      checkOutput("abort_out_req", 32'(outReq), 32'd0);
      applyStimulus(8'h02, 8'h8E, "after_abort");
      releaseOutput("after_abort");

      // Random operands with random consumer delay.
      for (nRand = 0; nRand < 24; nRand++) begin
         randA = 8'($urandom_range(0, 255));
         applyStimulus(randA, gfInvRef(int'(randA)), "rand");
         repeat ($urandom_range(0, 3)) begin
            tick();
            checkOutput("rand_stable", 32'(outData), 32'(gfInvRef(int'(randA))));
         end
         releaseOutput("rand");
      end

      // Full sweep at maximum throughput with both handshakes held high.
      inReq      = 1'b1;
      outAck     = 1'b1;
      prevAccept = 0;
      for (int a = 1; a < 256; a++) begin
         inData = 8'(a);
         guard  = 0;
         while (inAck !== 1'b1 && guard < 50) begin
            tick();
            guard++;
         end
         checkOutput("sweep_accept_timeout", 32'(guard >= 50), 32'd0);
         tick();
         accCyc = cyc;
         if (a > 1) checkOutput("sweep_spacing", 32'(accCyc - prevAccept), 32'(PeriodExp));
         prevAccept = accCyc;
         guard = 0;
         while (outReq !== 1'b1 && guard < 100) begin
            tick();
            guard++;
         end
         checkOutput("sweep_product", 32'(gfMulRef(int'(outData), a)), 32'd1);
         checkOutput("sweep_chk", 32'(outChkFail), 32'd0);
      end
      inReq = 1'b0;
      tick();
      outAck = 1'b0;
      checkOutput("sweep_end_idle", 32'({outReq, inAck}), 32'b01);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
